// File: rtl/div_seq.sv
// Sequential signed divider for the DIV instruction of the multicycle control unit.
// Restoring division, one quotient bit per cycle; quotient to LO, remainder to HI.
// Optional feature: define DIV_DIVU_EN to add the Unsigned input (DIVU semantics).
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIV_DIVU_EN
  input  logic             Unsigned,
`endif
  output logic             DivOut,
  output logic             divZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  dvd_q;      // dividend magnitude, becomes the quotient as it shifts out
  logic [WIDTH-1:0]  dvs_q;      // divisor magnitude
  logic [WIDTH-1:0]  rem_q;      // partial remainder
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic              uns;
  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH:0]    diff;

  // Operand magnitudes and the trial subtraction of the current step.
  always_comb begin
`ifdef DIV_DIVU_EN
    uns   = Unsigned;
`else
    uns   = 1'b0;
`endif
    a_neg = A[WIDTH-1] & ~uns;
    b_neg = B[WIDTH-1] & ~uns;
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
    // One extra bit: the shifted remainder can exceed WIDTH bits when |B| is large.
    diff  = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      DivOut    <= 1'b0;
      divZero   <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (DivCtrl) begin
            if (B == '0) begin
              divZero <= 1'b1;
              state_q <= StDone;
            end else begin
              dvd_q     <= a_mag;
              dvs_q     <= b_mag;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              rem_q     <= '0;
              cnt_q     <= CntW'(WIDTH);
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          if (!DivCtrl) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            if (!diff[WIDTH]) begin
              rem_q <= diff[WIDTH-1:0];
              dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
              dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_q <= StSign;
            end
          end
        end
        StSign: begin
          if (!DivCtrl) begin
            state_q <= StIdle;
          end else begin
            LO      <= neg_quo_q ? -dvd_q : dvd_q;
            HI      <= neg_rem_q ? -rem_q : rem_q;
            DivOut  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (!DivCtrl) begin
            DivOut  <= 1'b0;
            divZero <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (WIDTH=32) with a result scoreboard.
module tb_div_seq;

  logic        clk;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        DivOut;
  logic        divZero;
  logic [31:0] HI;
  logic [31:0] LO;
`ifdef DIV_DIVU_EN
  logic        Unsigned;
`endif

  div_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .DivCtrl (DivCtrl),
    .A       (A),
    .B       (B),
`ifdef DIV_DIVU_EN
    .Unsigned(Unsigned),
`endif
    .DivOut  (DivOut),
    .divZero (divZero),
    .HI      (HI),
    .LO      (LO)
  );

  typedef struct packed {
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_bad;
  int          cyc;
  int          start_cyc;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result from unsigned magnitudes; divide-by-zero keeps HI/LO.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic uns);
    exp_t        e;
    logic        an, bn;
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) begin
      e.zero = 1'b1;
      e.hi   = last_hi;
      e.lo   = last_lo;
      return e;
    end
    an = a[31] & ~uns;
    bn = b[31] & ~uns;
    ma = an ? 32'd0 - a : a;
    mb = bn ? 32'd0 - b : b;
    q  = ma / mb;
    r  = ma % mb;
    e.zero = 1'b0;
    e.lo   = (an ^ bn) ? 32'd0 - q : q;
    e.hi   = an ? 32'd0 - r : r;
    return e;
  endfunction

  task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic uns,
                           input bit push);
    @(negedge clk);
    A       = a;
    B       = b;
`ifdef DIV_DIVU_EN
    Unsigned = uns;
`endif
    DivCtrl = 1'b1;
    start_cyc = cyc + 1;
    if (push) sb_q.push_back(model(a, b, uns));
  endtask

  task automatic wait_resp();
    exp_t e;
    int   lat;
    while (!(DivOut || divZero) && (cyc - start_cyc) < 100) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - start_cyc;
    check_eq("done_seen", {31'd0, DivOut | divZero}, 32'd1);
    if (sb_q.size() == 0) begin
      check_eq("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_eq("latency", 32'(lat), e.zero ? 32'd0 : 32'd33);
    check_eq("divZero", {31'd0, divZero}, {31'd0, e.zero});
    check_eq("DivOut", {31'd0, DivOut}, {31'd0, ~e.zero});
    check_eq("LO", LO, e.lo);
    check_eq("HI", HI, e.hi);
    if (!e.zero) begin
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  task automatic end_req();
    @(negedge clk);
    DivCtrl = 1'b0;
    @(posedge clk);
    #1;
    check_eq("drop_DivOut", {31'd0, DivOut}, 32'd0);
    check_eq("drop_divZero", {31'd0, divZero}, 32'd0);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic uns);
    start_req(a, b, uns, 1'b1);
    wait_resp();
    end_req();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_DivOut"}, {31'd0, DivOut}, 32'd0);
    check_eq({tag, "_divZero"}, {31'd0, divZero}, 32'd0);
    check_eq({tag, "_HI"}, HI, 32'd0);
    check_eq({tag, "_LO"}, LO, 32'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    cyc     = 0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    reset   = 1'b0;
    DivCtrl = 1'b0;
    A       = 32'd0;
    B       = 32'd0;
`ifdef DIV_DIVU_EN
    Unsigned = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Signed corner cases.
    do_div(32'd7, 32'd2, 1'b0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef DIV_DIVU_EN
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
`endif

    // Divide by zero leaves the 9/4 result in place.
    do_div(32'd9, 32'd4, 1'b0);
    do_div(32'd5, 32'd0, 1'b0);

    // Abort after five CALC steps: HI/LO untouched, no completion.
    start_req(32'd100, 32'd3, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    DivCtrl = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_DivOut", {31'd0, DivOut}, 32'd0);
    check_eq("abort_HI", HI, last_hi);
    check_eq("abort_LO", LO, last_lo);
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_late_DivOut", {31'd0, DivOut}, 32'd0);
    check_eq("abort_late_LO", LO, last_lo);

    // Operands changed mid-CALC must not affect the result.
    start_req(32'd1000, 32'hFFFF_FFF9, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    A = 32'hDEAD_BEEF;
    B = 32'd0;
    wait_resp();
    end_req();

    // Reset at CALC step 10 with DivCtrl held, then a fresh division after release.
    start_req(32'd12345, 32'd17, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset     = 1'b1;
    last_hi   = 32'd0;
    last_lo   = 32'd0;
    start_cyc = cyc + 1;
    sb_q.push_back(model(32'd12345, 32'd17, 1'b0));
    wait_resp();
    end_req();

    // Random signed operands.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 2) rb = 32'd0 - rb;
      if (rb == 32'd0) rb = 32'd3;
      do_div(ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential signed divider that serves the DIV instruction for the multicycle control unit. It answers the control unit's `DivCtrl` request, runs one restoring-division step per cycle, and returns quotient on LO and remainder on HI with a `DivOut` completion flag. A zero divisor is reported on `divZero` so the control unit can branch to its divide-by-zero exception state.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `DivCtrl`  input  1  request from the control unit; level, held high until the response is seen.
- `A`  input  WIDTH  dividend (rs), two's complement.
- `B`  input  WIDTH  divisor (rt), two's complement.
- `DivOut`  output  1  result valid; HI/LO hold the final values while high.
- `divZero`  output  1  divisor was zero; no division performed.
- `HI`  output  WIDTH  remainder register.
- `LO`  output  WIDTH  quotient register.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE: when `DivCtrl`=1:
  - If `B`=0, set `divZero`=1 and go to DONE. `HI` and `LO` are unchanged.
  - Otherwise latch |A|, |B|, sign(A) and sign(A)^sign(B), clear the partial remainder, load the step counter with WIDTH, and go to CALC.
- CALC: one restoring step per cycle.
  - Shift the remainder left, bringing in the next dividend MSB.
  - Trial-subtract |B|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter. When it reaches 0, go to SIGN.
- SIGN: `LO` = quotient, negated if the signs differed. `HI` = remainder, negated if the dividend was negative. Set `DivOut`=1 and go to DONE.
- DONE: hold `DivOut`/`divZero` until `DivCtrl`=0 (four-phase handshake), then clear both flags and return to IDLE.
- Magnitudes are unsigned WIDTH-bit values, so |−2^(WIDTH−1)| = 2^(WIDTH−1) is exact.
  - −2^(WIDTH−1) / −1 gives LO=0x80000000 and HI=0 (wraps, no trap).
- `A`/`B` are sampled only in the IDLE start cycle. Later changes are ignored.
- `DivCtrl` dropping while in CALC or SIGN aborts: return to IDLE with HI/LO not updated and flags 0.
- HI/LO are written only in SIGN.

## Timing
- Reset (`reset`=0 at a clock edge): state=IDLE, `DivOut`=0, `divZero`=0, `HI`=0, `LO`=0, counter=0. Reset takes priority in every state, including mid-CALC.
- Request sampled at edge k:
  - CALC steps occur at edges k+1 … k+WIDTH.
  - SIGN executes at edge k+WIDTH+1, so `DivOut` is high after that edge.
  - Latency from the sampling edge is WIDTH+1 edges (33 for WIDTH=32).
- Zero divisor: `divZero` is high after edge k (1-cycle latency) and `DivOut` stays 0.
- `DivOut`/`divZero` fall on the first edge that sees `DivCtrl`=0 in DONE.
- A new request is accepted no earlier than the following edge, from IDLE.
- `DivOut` and `divZero` are never high at the same time.

## Configuration
- `DIV_DIVU_EN`:
  - When defined, adds input `Unsigned` (1 bit), sampled with the operands.
  - `Unsigned`=1 skips the absolute-value and sign-fix steps and treats A/B as unsigned (DIVU semantics). SIGN still costs one cycle.
  - When not defined, the port is absent and all divisions are signed.

## Test plan
- A=7, B=2, `DivCtrl` held high → `DivOut`=1 exactly 33 edges after the start edge, LO=3, HI=1; `DivCtrl` dropped → `DivOut`=0 next edge.
- A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. A=7, B=−2 → LO=0xFFFFFFFD, HI=1.
- A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0; with `DIV_DIVU_EN` and `Unsigned`=1 → LO=0, HI=0x80000000.
- B=0, HI/LO preloaded by a prior 9/4 division → `divZero`=1 one edge after start, `DivOut` stays 0, HI=1 and LO=2 unchanged.
- `reset`=0 at step 10 of CALC → all outputs 0 next edge; `DivCtrl` still high after reset releases → a fresh division starts from IDLE.
- `DivCtrl` dropped at step 5 → IDLE, HI/LO keep their previous values; `A`/`B` changed mid-CALC in another run → result unaffected.
